// File: rtl/vga_capture.sv
// Receive side of the VGA link. It recovers the raster position from the sync edges,
// checks line and frame lengths against the expected timing, and writes visible pixels once locked.
module vga_capture #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int H_START     = 144,
   parameter int V_START     = 35,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   input  logic [2:0] pixel_in,
   input  logic       hsync_in,
   input  logic       vsync_in,
   output logic       wr_en,
   output logic [9:0] wr_x,
   output logic [8:0] wr_y,
   output logic [2:0] wr_data,
   output logic       frame_start,
   output logic [9:0] h_total,
   output logic [9:0] v_total,
   output logic       locked
);

   localparam logic [9:0] H_TOTAL_C = 10'(H_TOTAL);
   localparam logic [9:0] V_TOTAL_C = 10'(V_TOTAL);
   localparam logic [9:0] H_START_C = 10'(H_START);
   localparam logic [9:0] V_START_C = 10'(V_START);
   localparam logic [9:0] H_END_C   = 10'(H_START + H_ACTIVE);
   localparam logic [9:0] V_END_C   = 10'(V_START + V_ACTIVE);
   localparam logic [9:0] CNT_MAX   = 10'h3ff;
   localparam logic [7:0] LOCK_C    = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

   // sample stage
   logic       s1_valid_q, s1_valid_d;
   logic [2:0] s1_pix_q, s1_pix_d;
   logic       hs_q, hs_d, hs_prev_q, hs_prev_d;
   logic       vs_q, vs_d, vs_prev_q, vs_prev_d;

   // position / measurement stage
   logic       s2_valid_q, s2_valid_d;
   logic [2:0] s2_pix_q, s2_pix_d;
   logic       s2_frame_q, s2_frame_d;
   logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic       vpend_q, vpend_d;
   logic [9:0] h_total_q, h_total_d, v_total_q, v_total_d;
   state_t     state_q, state_d;
   logic [7:0] good_q, good_d;
   logic       line_ok_q, line_ok_d;

   // write stage
   logic       wr_en_q, wr_en_d;
   logic [9:0] wr_x_q, wr_x_d;
   logic [8:0] wr_y_q, wr_y_d;
   logic [2:0] wr_data_q, wr_data_d;
   logic       frame_start_q, frame_start_d;

   logic       line_edge, vs_fall, frame_edge, sat;
   logic       line_bad, frame_bad, frame_good;
   logic [9:0] line_len, frame_len;
   logic [7:0] good_inc;
   logic       h_vis, v_vis;

   always_comb begin
      s1_valid_d = pix_en;
      s1_pix_d   = s1_pix_q;
      hs_d       = hs_q;
      hs_prev_d  = hs_prev_q;
      vs_d       = vs_q;
      vs_prev_d  = vs_prev_q;
      if (pix_en) begin
         s1_pix_d  = pixel_in;
         hs_d      = hsync_in;
         hs_prev_d = hs_q;
         vs_d      = vsync_in;
         vs_prev_d = vs_q;
      end
   end

   assign line_edge  = s1_valid_q & hs_prev_q & ~hs_q;
   assign vs_fall    = s1_valid_q & vs_prev_q & ~vs_q;
   assign frame_edge = line_edge & (vpend_q | vs_fall);
   assign line_len   = hcnt_q + 10'd1;
   assign frame_len  = vcnt_q + 10'd1;

   always_comb begin
      hcnt_d     = hcnt_q;
      vcnt_d     = vcnt_q;
      vpend_d    = vpend_q;
      h_total_d  = h_total_q;
      v_total_d  = v_total_q;
      s2_valid_d = s1_valid_q;
      s2_pix_d   = s1_pix_q;
      s2_frame_d = frame_edge;
      if (s1_valid_q) begin
         if (line_edge) begin
            h_total_d = line_len;
            hcnt_d    = 10'd0;
         end else if (hcnt_q != CNT_MAX) begin
            hcnt_d = hcnt_q + 10'd1;
         end
         if (frame_edge) begin
            v_total_d = frame_len;
            vcnt_d    = 10'd0;
            vpend_d   = 1'b0;
         end else begin
            if (vs_fall) vpend_d = 1'b1;
            if (line_edge && vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 10'd1;
         end
      end
   end

   // A counter reaching its ceiling means the syncs have gone missing.
   assign sat        = s1_valid_q & ((hcnt_d == CNT_MAX) | (vcnt_d == CNT_MAX));
   assign line_bad   = line_edge & (line_len != H_TOTAL_C);
   assign frame_bad  = (frame_len != V_TOTAL_C);
   assign frame_good = line_ok_q & ~line_bad & ~frame_bad;
   assign good_inc   = good_q + 8'd1;

   always_comb begin
      state_d   = state_q;
      good_d    = good_q;
      line_ok_d = line_ok_q;
      case (state_q)
         SEARCH: begin
            if (frame_edge) begin
               good_d    = 8'd0;
               line_ok_d = 1'b1;
               state_d   = CHECK;
            end
         end
         CHECK: begin
            if (frame_edge) begin
               line_ok_d = 1'b1;
               if (frame_good) begin
                  good_d = good_inc;
                  if (good_inc >= LOCK_C) state_d = LOCKED;
               end else begin
                  good_d = 8'd0;
               end
            end else if (line_bad) begin
               line_ok_d = 1'b0;
            end
         end
         LOCKED: begin
            if (line_bad || (frame_edge && frame_bad) || sat) state_d = SEARCH;
         end
         default: state_d = SEARCH;
      endcase
   end

   // state_q already reflects this sample's decision, so an unlock suppresses its own write.
   assign h_vis = (hcnt_q >= H_START_C) && (hcnt_q < H_END_C);
   assign v_vis = (vcnt_q >= V_START_C) && (vcnt_q < V_END_C);

   always_comb begin
      wr_en_d       = s2_valid_q & (state_q == LOCKED) & h_vis & v_vis;
      wr_x_d        = wr_x_q;
      wr_y_d        = wr_y_q;
      wr_data_d     = wr_data_q;
      frame_start_d = s2_valid_q & s2_frame_q;
      if (wr_en_d) begin
         wr_x_d    = hcnt_q - H_START_C;
         wr_y_d    = 9'(vcnt_q - V_START_C);
         wr_data_d = s2_pix_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q    <= 1'b0;
         s1_pix_q      <= 3'd0;
         hs_q          <= 1'b1;
         hs_prev_q     <= 1'b1;
         vs_q          <= 1'b1;
         vs_prev_q     <= 1'b1;
         s2_valid_q    <= 1'b0;
         s2_pix_q      <= 3'd0;
         s2_frame_q    <= 1'b0;
         hcnt_q        <= 10'd0;
         vcnt_q        <= 10'd0;
         vpend_q       <= 1'b0;
         h_total_q     <= 10'd0;
         v_total_q     <= 10'd0;
         state_q       <= SEARCH;
         good_q        <= 8'd0;
         line_ok_q     <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_x_q        <= 10'd0;
         wr_y_q        <= 9'd0;
         wr_data_q     <= 3'd0;
         frame_start_q <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_pix_q      <= s1_pix_d;
         hs_q          <= hs_d;
         hs_prev_q     <= hs_prev_d;
         vs_q          <= vs_d;
         vs_prev_q     <= vs_prev_d;
         s2_valid_q    <= s2_valid_d;
         s2_pix_q      <= s2_pix_d;
         s2_frame_q    <= s2_frame_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         vpend_q       <= vpend_d;
         h_total_q     <= h_total_d;
         v_total_q     <= v_total_d;
         state_q       <= state_d;
         good_q        <= good_d;
         line_ok_q     <= line_ok_d;
         wr_en_q       <= wr_en_d;
         wr_x_q        <= wr_x_d;
         wr_y_q        <= wr_y_d;
         wr_data_q     <= wr_data_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_x        = wr_x_q;
   assign wr_y        = wr_y_q;
   assign wr_data     = wr_data_q;
   assign frame_start = frame_start_q;
   assign h_total     = h_total_q;
   assign v_total     = v_total_q;
   assign locked      = (state_q == LOCKED);

endmodule

// File: doc/vga_capture.md
# vga_capture

Receive side of the VGA link. The block samples a 3-bit pixel bus plus negative-polarity hsync/vsync (640x480@60 timing, one pixel per `pix_en` strobe), recovers the raster position from the sync edges, and checks the stream against the expected timing. Once locked, it emits one framebuffer write per visible pixel. It sits between the external VGA pins (or the loopback from the VGA generator) and a capture framebuffer write port.

## Interface
- `H_TOTAL`, 800: pixels per line expected
- `V_TOTAL`, 525: lines per frame expected
- `H_START`, 144: pixel index (from hsync falling edge) of first visible pixel
- `V_START`, 35: line index (from vsync-qualified line) of first visible line
- `H_ACTIVE`, 640: visible pixels per line
- `V_ACTIVE`, 480: visible lines per frame
- `LOCK_FRAMES`, 2: consecutive good frames required for lock
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  reset, asynchronous, active-low
- `pix_en`  in  1  pixel strobe; inputs are sampled only in cycles where it is high; may be high every cycle or every other cycle
- `pixel_in`  in  3  RGB pixel
- `hsync_in`  in  1  horizontal sync, active-low, synchronous to `clk`
- `vsync_in`  in  1  vertical sync, active-low, synchronous to `clk`
- `wr_en`  out  1  one-cycle framebuffer write strobe
- `wr_x`  out  10  visible column, 0..H_ACTIVE-1
- `wr_y`  out  9  visible row, 0..V_ACTIVE-1
- `wr_data`  out  3  captured pixel
- `frame_start`  out  1  one-cycle pulse at each frame boundary
- `h_total`  out  10  last measured line length, in pixels
- `v_total`  out  10  last measured frame length, in lines
- `locked`  out  1  timing matches the parameters

## Operation
- **Sample stage:** on a `pix_en` cycle, register `pixel_in`, `hsync_in` and `vsync_in`. The previously registered sync values are kept for edge detection. Nothing changes in cycles without `pix_en`.
- **Line edge:** sampled hsync 1→0.
  - `h_total` ← `hcnt`+1.
  - `hcnt` ← 0. The pixel sampled with hsync first low has index 0.
  - Otherwise `hcnt` increments and saturates at 1023.
- **Frame edge:** a sampled vsync 1→0 sets `vpend`.
  - At the next line edge: `v_total` ← `vcnt`+1, `vcnt` ← 0, `vpend` cleared, `frame_start` pulses.
  - If the vsync and hsync falling edges fall on the same sample, the frame edge applies at that line edge.
  - Without a frame edge, each line edge increments `vcnt`, which saturates at 1023.
- **Lock FSM:**
  - `SEARCH`: at the first frame edge, clear the good-frame count, set `line_ok`, go to `CHECK`.
  - `CHECK`:
    - At every line edge, `line_ok` is cleared if the measured length ≠ `H_TOTAL`.
    - At a frame edge: if `line_ok` and `v_total` = `V_TOTAL`, increment the good-frame count; else reset it to 0. `line_ok` is re-set either way.
    - When the count reaches `LOCK_FRAMES`, go to `LOCKED`.
  - `LOCKED`: any line length ≠ `H_TOTAL`, any `v_total` ≠ `V_TOTAL`, or either counter saturating → `SEARCH`.
  - `locked` is high only in `LOCKED`.
- **Write generation:** only while `LOCKED`, and only for samples with `H_START` ≤ `hcnt` < `H_START+H_ACTIVE` and `V_START` ≤ `vcnt` < `V_START+V_ACTIVE`.
  - `wr_x` = `hcnt`-`H_START`, `wr_y` = `vcnt`-`V_START`, truncated to port width.
  - `wr_data` = the sampled pixel.
  - Leaving `LOCKED` suppresses writes from the same sample on.
- **Held outputs:** `wr_x`, `wr_y` and `wr_data` hold their value when `wr_en` is low.

## Timing
- **Reset:** all outputs are 0 and the FSM is in `SEARCH`. Assertion mid-frame takes effect immediately. After release, `LOCKED` requires a fresh first frame edge plus `LOCK_FRAMES` full good frames.
- **Write latency:** `wr_en` rises exactly 2 `clk` edges after the edge that samples the corresponding `pix_en` cycle. It is high for exactly one cycle per visible pixel. With `pix_en` held high, back-to-back writes occur every cycle.
- **Frame pulse:** `frame_start` has the same 2-edge latency relative to the qualifying hsync sample.
- **Measurements:** `h_total` and `v_total` update on the same edge as the counter clears. `locked` changes on the edge after the deciding line or frame edge.
- **Per frame while locked:** exactly `H_ACTIVE`×`V_ACTIVE` writes, in raster order, (0,0) first and (639,479) last.

## Test plan
- Ideal 800x525 source from reset, `pix_en` every other cycle → `locked` rises after the 3rd frame edge. Frame 4 gives 307200 writes, first at (0,0), last at (639,479). `h_total`=800, `v_total`=525.
- Same source with `pix_en` every cycle → identical write sequence, `wr_en` spaced one cycle apart. Latency from the sampled pixel to `wr_en` = 2 edges.
- Once locked, one line of 799 pixels injected → `locked` falls after that line edge and writes stop mid-frame. Relock occurs after the next frame edge plus 2 good frames.
- Once locked, vsync removed → `vcnt` saturates at 1023, `locked` drops, no writes afterwards.
- `rst` asserted mid-line while locked → all outputs 0 immediately. After release, no writes until lock is reacquired.
- Pixel pattern `wr_data` = (x+y) mod 8 → every write matches the pattern at its (x,y). Edge pixels at x=639 and y=479 are present; samples with `hcnt`=143 or `hcnt`=784 are not written.
